signal_capture_fifo: RTL and testbench

- Parametrised multi-channel successor to the single 32-bit signal export into the HPS.
- Samples N FSK-datapath channels and timestamps each word with its channel ID.
- Buffers words in a shared FIFO, read by the HPS over an Avalon-MM slave (lightweight bridge).
- Adds per-channel masking, continuous/one-shot capture, overflow/underflow flags and a threshold interrupt.

---
 rtl/signal_capture_fifo_if.sv | 40 ++++
 rtl/signal_capture_fifo.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_signal_capture_fifo.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/signal_capture_fifo_if.sv
// Avalon-MM bus between the HPS lightweight bridge and the capture FIFO.
//
// master modport: HPS side. It drives address, read, write and writedata, and
//                 receives readdata and irq.
// slave modport:  capture block side. It receives address, read, write and
//                 writedata, and drives readdata and irq.
//
// Signals:
//   avs_address   [1:0]  word address
//   avs_read             read strobe
//   avs_write            write strobe
//   avs_writedata [31:0] write data
//   avs_readdata  [31:0] read data, valid the cycle after avs_read
//   irq                  level interrupt to the HPS
interface signal_capture_fifo_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata,
        input  irq
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata,
        output irq
    );
endinterface

// File: rtl/signal_capture_fifo.sv
// Multi-channel signal capture into a shared FIFO, which the HPS reads over an
// Avalon-MM slave.
//
// Each enabled channel has a 1-deep holding register. A round-robin arbiter
// moves one held sample per cycle into the FIFO, and tags it with its channel
// ID. Capture can run continuously or as a one-shot of a programmed length.
//
// Ports:
//   clk_clk      system clock
//   reset_reset  asynchronous active-high reset
//   sig_data     channel samples; channel k is sig_data[k*DATA_W +: DATA_W]
//   sig_valid    per-channel single-cycle sample strobe
//   avs          Avalon-MM slave (address/read/write/writedata/readdata/irq)
//
// Register map (word addresses):
//   0 DATA   (R)   pop: {4'b0, ch_id[3:0], sample zero-extended to 24 bits}
//   1 STATUS (R/W1C) [15:0] count, [16] empty, [17] full, [18] overflow,
//                    [19] underflow, [20] done, [22:21] state
//   2 CTRL   (RW)  [0] enable, [1] one_shot, [CH+7:8] mask, [31] flush (write-only)
//   3 THRESH (RW)  [15:0] irq threshold, [31:16] one-shot length (0 = unbounded)
module signal_capture_fifo #(
    parameter int unsigned CH     = 4,
    parameter int unsigned DATA_W = 24,
    parameter int unsigned DEPTH  = 64
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [CH*DATA_W-1:0] sig_data,
    input  logic [CH-1:0]        sig_valid,
    signal_capture_fifo_if.slave avs
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned EW = 4 + DATA_W;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Registers
    state_e              state_q;
    logic                ctrl_enable_q;
    logic                ctrl_one_shot_q;
    logic [CH-1:0]       ctrl_mask_q;
    logic [15:0]         thresh_q;
    logic [15:0]         shot_len_q;
    logic [15:0]         shot_cnt_q;
    logic                ovf_q;
    logic                udf_q;
    logic                done_q;
    logic [PW-1:0]       wr_ptr_q;
    logic [PW-1:0]       rd_ptr_q;
    logic [CH-1:0]       hold_valid_q;
    logic [DATA_W-1:0]   hold_data_q [CH];
    logic [CW-1:0]       last_grant_q;
    logic [31:0]         readdata_q;
    logic                irq_q;
    logic [EW-1:0]       mem_q [DEPTH];

    // Combinational
    logic [31:0]         wdata;
    logic                rd_req;
    logic                rd_data;
    logic                wr_status;
    logic                wr_ctrl;
    logic                wr_thresh;
    logic                flush;
    logic [PW-1:0]       count;
    logic [15:0]         count16;
    logic                empty;
    logic                full;
    logic                pop;
    logic                gnt_valid;
    logic [CW-1:0]       gnt_idx;
    logic [CH-1:0]       gnt_oh;
    logic                push_ok;
    logic                push_drop;
    logic                shot_hit;
    logic [CH-1:0]       cap;
    logic [CH-1:0]       load;
    logic [CH-1:0]       drop;
    logic                ovf_evt;
    logic [EW-1:0]       head;
    logic [31:0]         status_rd;
    logic [31:0]         ctrl_rd;
    logic [31:0]         rd_mux;
    logic                unused_wdata;

    assign wdata        = avs.avs_writedata;
    assign unused_wdata = ^wdata;

    // A read that coincides with a write is dropped: the write wins.
    assign rd_req    = avs.avs_read && !avs.avs_write;
    assign rd_data   = rd_req && (avs.avs_address == 2'd0);
    assign wr_status = avs.avs_write && (avs.avs_address == 2'd1);
    assign wr_ctrl   = avs.avs_write && (avs.avs_address == 2'd2);
    assign wr_thresh = avs.avs_write && (avs.avs_address == 2'd3);
    assign flush     = wr_ctrl && wdata[31];

    assign count   = wr_ptr_q - rd_ptr_q;
    assign count16 = 16'(count);
    assign empty   = (count == '0);
    assign full    = (count == PW'(DEPTH));
    assign pop     = rd_data && !empty;

    function automatic logic [CW-1:0] rr_index(input logic [CW-1:0] last, input int unsigned off);
        int unsigned s;
        s = 32'(last) + 32'd1 + off;
        return CW'(s % CH);
    endfunction

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < CH; i++) begin
            if (!gnt_valid && hold_valid_q[rr_index(last_grant_q, i)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = rr_index(last_grant_q, i);
            end
        end
    end

    assign gnt_oh = gnt_valid ? (CH'(1) << gnt_idx) : '0;

    // A full FIFO still accepts a push if a pop happens on the same cycle.
    assign push_ok   = gnt_valid && !flush && (!full || pop);
    assign push_drop = gnt_valid && !flush && full && !pop;

    assign shot_hit = (state_q == StRun) && ctrl_one_shot_q && (shot_len_q != 16'd0) &&
                      push_ok && ((shot_cnt_q + 16'd1) == shot_len_q);

    // A holding register being granted this cycle can take a new sample at once.
    // Samples are ignored on the cycle a shot completes, so the shot stays exact.
    assign cap  = ((state_q == StRun) && !flush && !shot_hit) ? (sig_valid & ctrl_mask_q) : '0;
    assign load = cap & (~hold_valid_q | gnt_oh);
    assign drop = cap & hold_valid_q & ~gnt_oh;

    assign ovf_evt = (|drop) || push_drop;

    assign head = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        status_rd        = '0;
        status_rd[15:0]  = count16;
        status_rd[16]    = empty;
        status_rd[17]    = full;
        status_rd[18]    = ovf_q;
        status_rd[19]    = udf_q;
        status_rd[20]    = done_q;
        status_rd[22:21] = state_q;
    end

    always_comb begin
        ctrl_rd          = '0;
        ctrl_rd[0]       = ctrl_enable_q;
        ctrl_rd[1]       = ctrl_one_shot_q;
        ctrl_rd[CH+7:8]  = ctrl_mask_q;
    end

    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            2'd0:    rd_mux = empty ? 32'd0 : {4'b0, head[EW-1 -: 4], 24'(head[DATA_W-1:0])};
            2'd1:    rd_mux = status_rd;
            2'd2:    rd_mux = ctrl_rd;
            default: rd_mux = {shot_len_q, thresh_q};
        endcase
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {4'(gnt_idx), hold_data_q[gnt_idx]};
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q         <= StIdle;
            ctrl_enable_q   <= 1'b0;
            ctrl_one_shot_q <= 1'b0;
            ctrl_mask_q     <= '0;
            thresh_q        <= 16'(DEPTH / 2);
            shot_len_q      <= '0;
            shot_cnt_q      <= '0;
            ovf_q           <= 1'b0;
            udf_q           <= 1'b0;
            done_q          <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            hold_valid_q    <= '0;
            for (int k = 0; k < CH; k++) begin
                hold_data_q[k] <= '0;
            end
            last_grant_q    <= CW'(CH - 1);
            readdata_q      <= '0;
            irq_q           <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_enable_q   <= wdata[0];
                ctrl_one_shot_q <= wdata[1];
                ctrl_mask_q     <= wdata[CH+7:8];
            end
            if (wr_thresh) begin
                thresh_q   <= wdata[15:0];
                shot_len_q <= wdata[31:16];
            end

            case (state_q)
                StIdle: begin
                    if (wr_ctrl && wdata[0]) begin
                        state_q    <= StRun;
                        shot_cnt_q <= '0;
                    end
                end
                StRun: begin
                    if (push_ok) begin
                        shot_cnt_q <= shot_cnt_q + 16'd1;
                    end
                    if (shot_hit) begin
                        state_q       <= StDone;
                        ctrl_enable_q <= 1'b0;
                    end else if (wr_ctrl && !wdata[0]) begin
                        state_q <= StIdle;
                    end
                end
                StDone: begin
                    if (wr_ctrl && wdata[0]) begin
                        state_q    <= StRun;
                        shot_cnt_q <= '0;
                    end else if (wr_status && wdata[20]) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Sticky flags: a set event beats a same-cycle W1C.
            if (wr_status && wdata[18]) ovf_q <= 1'b0;
            if (ovf_evt) ovf_q <= 1'b1;
            if (wr_status && wdata[19]) udf_q <= 1'b0;
            if (rd_data && empty) udf_q <= 1'b1;
            if (wr_status && wdata[20]) done_q <= 1'b0;
            if (shot_hit) done_q <= 1'b1;

            if (flush) begin
                rd_ptr_q <= wr_ptr_q;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            for (int k = 0; k < CH; k++) begin
                if (flush || shot_hit) begin
                    hold_valid_q[k] <= 1'b0;
                end else if (load[k]) begin
                    hold_valid_q[k] <= 1'b1;
                    hold_data_q[k]  <= sig_data[k*DATA_W +: DATA_W];
                end else if (gnt_oh[k]) begin
                    hold_valid_q[k] <= 1'b0;
                end
            end

            if (gnt_valid) begin
                last_grant_q <= gnt_idx;
            end

            readdata_q <= rd_req ? rd_mux : 32'd0;
            irq_q      <= ((thresh_q != 16'd0) && (count16 >= thresh_q)) || ovf_q || done_q;
        end
    end

    assign avs.avs_readdata = readdata_q;
    assign avs.irq          = irq_q;

endmodule

// File: tb/tb_signal_capture_fifo.sv
// Directed testbench for signal_capture_fifo (CH=4, DATA_W=24, DEPTH=64).
module tb_signal_capture_fifo;
    logic        clk;
    logic        rst;
    logic [95:0] sig_data;
    logic [3:0]  sig_valid;
    int          checks;
    int          failures;
    logic [31:0] rd;

    signal_capture_fifo_if bus ();

    signal_capture_fifo #(
        .CH     (4),
        .DATA_W (24),
        .DEPTH  (64)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .sig_data    (sig_data),
        .sig_valid   (sig_valid),
        .avs         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        step(1);
        bus.avs_write     = 1'b0;
    endtask

    task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        step(1);
        bus.avs_read    = 1'b0;
        d = bus.avs_readdata;
    endtask

    task automatic set_ch(input int k, input logic [23:0] v);
        sig_data[k*24 +: 24] = v;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        if (bus.avs_readdata !== 32'd0) begin
            $display("FAIL reset_readdata got=%h exp=%h", bus.avs_readdata, 32'd0);
            failures++;
        end
        checks++;
        if (bus.irq !== 1'b0) begin
            $display("FAIL reset_irq got=%b exp=0", bus.irq);
            failures++;
        end
        checks++;
        step(2);
        rst = 1'b0;
        step(1);
        avs_rd(2'd3, rd);
        if (rd !== 32'h0000_0020) begin
            $display("FAIL reset_thresh got=%h exp=%h", rd, 32'h0000_0020);
            failures++;
        end
        checks++;
        avs_rd(2'd1, rd);
        if (rd !== 32'h0001_0000) begin
            $display("FAIL reset_status got=%h exp=%h", rd, 32'h0001_0000);
            failures++;
        end
        checks++;
    endtask

    task automatic test_channel_order;
        logic [31:0] exp_words [4];
        exp_words[0] = 32'h0000_0000;
        exp_words[1] = 32'h0100_0111;
        exp_words[2] = 32'h0200_0222;
        exp_words[3] = 32'h0300_0333;
        avs_wr(2'd2, 32'h0000_0F01);
        for (int k = 0; k < 4; k++) set_ch(k, 24'(k * 'h111));
        sig_valid = 4'hF;
        step(1);
        sig_valid = 4'h0;
        step(6);
        avs_rd(2'd1, rd);
        if (rd !== 32'h0020_0004) begin
            $display("FAIL order_status got=%h exp=%h", rd, 32'h0020_0004);
            failures++;
        end
        checks++;
        if (bus.irq !== 1'b0) begin
            $display("FAIL order_irq got=%b exp=0", bus.irq);
            failures++;
        end
        checks++;
        for (int k = 0; k < 4; k++) begin
            avs_rd(2'd0, rd);
            if (rd !== exp_words[k]) begin
                $display("FAIL order_data%0d got=%h exp=%h", k, rd, exp_words[k]);
                failures++;
            end
            checks++;
        end
    endtask

    task automatic test_fill_overflow;
        for (int i = 0; i < 64; i++) begin
            set_ch(0, 24'('h100 + i));
            sig_valid = 4'h1;
            step(1);
        end
        sig_valid = 4'h0;
        step(3);
        avs_rd(2'd1, rd);
        if (rd !== 32'h0022_0040) begin
            $display("FAIL fill_status got=%h exp=%h", rd, 32'h0022_0040);
            failures++;
        end
        checks++;
        set_ch(0, 24'h999);
        sig_valid = 4'h1;
        step(1);
        sig_valid = 4'h0;
        step(3);
        avs_rd(2'd1, rd);
        if (rd !== 32'h0026_0040) begin
            $display("FAIL ovf_status got=%h exp=%h", rd, 32'h0026_0040);
            failures++;
        end
        checks++;
        if (bus.irq !== 1'b1) begin
            $display("FAIL ovf_irq got=%b exp=1", bus.irq);
            failures++;
        end
        checks++;
        avs_wr(2'd1, 32'h0004_0000);
        avs_rd(2'd1, rd);
        if (rd !== 32'h0022_0040) begin
            $display("FAIL ovf_w1c_status got=%h exp=%h", rd, 32'h0022_0040);
            failures++;
        end
        checks++;
        step(2);
        if (bus.irq !== 1'b1) begin
            $display("FAIL thresh_irq got=%b exp=1", bus.irq);
            failures++;
        end
        checks++;
    endtask

    task automatic test_push_pop_full;
        set_ch(0, 24'h777);
        sig_valid = 4'h1;
        step(1);
        sig_valid = 4'h0;
        avs_rd(2'd0, rd);
        if (rd !== 32'h0000_0100) begin
            $display("FAIL pushpop_data got=%h exp=%h", rd, 32'h0000_0100);
            failures++;
        end
        checks++;
        step(2);
        avs_rd(2'd1, rd);
        if (rd !== 32'h0022_0040) begin
            $display("FAIL pushpop_status got=%h exp=%h", rd, 32'h0022_0040);
            failures++;
        end
        checks++;
    endtask

    task automatic test_flush_underflow;
        avs_wr(2'd2, 32'h8000_0F01);
        avs_rd(2'd1, rd);
        if (rd !== 32'h0021_0000) begin
            $display("FAIL flush_status got=%h exp=%h", rd, 32'h0021_0000);
            failures++;
        end
        checks++;
        avs_rd(2'd2, rd);
        if (rd !== 32'h0000_0F01) begin
            $display("FAIL flush_ctrl got=%h exp=%h", rd, 32'h0000_0F01);
            failures++;
        end
        checks++;
        avs_rd(2'd0, rd);
        if (rd !== 32'd0) begin
            $display("FAIL udf_data got=%h exp=%h", rd, 32'd0);
            failures++;
        end
        checks++;
        avs_rd(2'd1, rd);
        if (rd !== 32'h0029_0000) begin
            $display("FAIL udf_status got=%h exp=%h", rd, 32'h0029_0000);
            failures++;
        end
        checks++;
        avs_wr(2'd1, 32'h0008_0000);
        avs_rd(2'd1, rd);
        if (rd !== 32'h0021_0000) begin
            $display("FAIL udf_w1c_status got=%h exp=%h", rd, 32'h0021_0000);
            failures++;
        end
        checks++;
    endtask

    task automatic test_reset_mid_run;
        avs_wr(2'd3, 32'h0000_0004);
        set_ch(0, 24'h055);
        for (int i = 0; i < 10; i++) begin
            sig_valid = 4'h1;
            step(1);
        end
        sig_valid = 4'h0;
        step(3);
        avs_rd(2'd1, rd);
        if (rd !== 32'h0020_000A) begin
            $display("FAIL midrun_status got=%h exp=%h", rd, 32'h0020_000A);
            failures++;
        end
        checks++;
        if (bus.irq !== 1'b1) begin
            $display("FAIL midrun_irq got=%b exp=1", bus.irq);
            failures++;
        end
        checks++;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        if (bus.irq !== 1'b0) begin
            $display("FAIL rst_irq got=%b exp=0", bus.irq);
            failures++;
        end
        checks++;
        avs_rd(2'd1, rd);
        if (rd !== 32'h0001_0000) begin
            $display("FAIL rst_status got=%h exp=%h", rd, 32'h0001_0000);
            failures++;
        end
        checks++;
        avs_rd(2'd3, rd);
        if (rd !== 32'h0000_0020) begin
            $display("FAIL rst_thresh got=%h exp=%h", rd, 32'h0000_0020);
            failures++;
        end
        checks++;
        avs_rd(2'd2, rd);
        if (rd !== 32'd0) begin
            $display("FAIL rst_ctrl got=%h exp=%h", rd, 32'd0);
            failures++;
        end
        checks++;
    endtask

    task automatic test_contention;
        logic [31:0] exp_words [3];
        exp_words[0] = 32'h0000_000A;
        exp_words[1] = 32'h0100_00B1;
        exp_words[2] = 32'h0300_000D;
        avs_wr(2'd2, 32'h0000_0F01);
        set_ch(0, 24'h00A);
        set_ch(1, 24'h0B1);
        set_ch(3, 24'h00D);
        sig_valid = 4'b1011;
        step(1);
        set_ch(1, 24'h0B2);
        sig_valid = 4'b0010;
        step(1);
        sig_valid = 4'h0;
        step(4);
        avs_rd(2'd1, rd);
        if (rd !== 32'h0024_0003) begin
            $display("FAIL cont_status got=%h exp=%h", rd, 32'h0024_0003);
            failures++;
        end
        checks++;
        for (int k = 0; k < 3; k++) begin
            avs_rd(2'd0, rd);
            if (rd !== exp_words[k]) begin
                $display("FAIL cont_data%0d got=%h exp=%h", k, rd, exp_words[k]);
                failures++;
            end
            checks++;
        end
        avs_wr(2'd1, 32'h0004_0000);
    endtask

    task automatic test_one_shot;
        avs_wr(2'd2, 32'h0000_0000);
        avs_wr(2'd3, 32'h0005_0020);
        avs_wr(2'd2, 32'h0000_0403);
        set_ch(2, 24'h022);
        sig_valid = 4'b0100;
        step(12);
        sig_valid = 4'h0;
        step(3);
        avs_rd(2'd1, rd);
        if (rd !== 32'h0050_0005) begin
            $display("FAIL shot_status got=%h exp=%h", rd, 32'h0050_0005);
            failures++;
        end
        checks++;
        avs_rd(2'd2, rd);
        if (rd !== 32'h0000_0402) begin
            $display("FAIL shot_ctrl got=%h exp=%h", rd, 32'h0000_0402);
            failures++;
        end
        checks++;
        if (bus.irq !== 1'b1) begin
            $display("FAIL shot_irq got=%b exp=1", bus.irq);
            failures++;
        end
        checks++;
        sig_valid = 4'b0100;
        step(3);
        sig_valid = 4'h0;
        step(3);
        avs_rd(2'd1, rd);
        if (rd !== 32'h0050_0005) begin
            $display("FAIL shot_ignore_status got=%h exp=%h", rd, 32'h0050_0005);
            failures++;
        end
        checks++;
        for (int i = 0; i < 5; i++) begin
            avs_rd(2'd0, rd);
            if (rd !== 32'h0200_0022) begin
                $display("FAIL shot_data%0d got=%h exp=%h", i, rd, 32'h0200_0022);
                failures++;
            end
            checks++;
        end
        avs_wr(2'd1, 32'h0010_0000);
        avs_rd(2'd1, rd);
        if (rd !== 32'h0001_0000) begin
            $display("FAIL done_clear_status got=%h exp=%h", rd, 32'h0001_0000);
            failures++;
        end
        checks++;
        step(2);
        if (bus.irq !== 1'b0) begin
            $display("FAIL done_clear_irq got=%b exp=0", bus.irq);
            failures++;
        end
        checks++;
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst               = 1'b1;
        sig_data          = '0;
        sig_valid         = '0;
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;

        test_reset();
        test_channel_order();
        test_fill_overflow();
        test_push_pop_full();
        test_flush_underflow();
        test_reset_mid_run();
        test_contention();
        test_one_shot();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
